psx_mem_arbiter: RTL



---
 rtl/psx_mem_pkg.sv | 26 ++
 rtl/psx_rr_arbiter.sv | 25 ++
 rtl/psx_mem_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/psx_mem_pkg.sv
// Shared types for the PSX memory arbiter: command sizes, FSM states and the
// latched request record.
package psx_mem_pkg;

    localparam logic [1:0] CMD_8BYTE  = 2'd0;
    localparam logic [1:0] CMD_32BYTE = 2'd1;
    localparam logic [1:0] CMD_4BYTE  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GUARD,
        ST_WAIT_WR,
        ST_WAIT_RD
    } arb_state_t;

    typedef struct packed {
        logic         write;
        logic [1:0]   size;
        logic [14:0]  addr;
        logic [2:0]   sub;
        logic [15:0]  mask;
        logic [255:0] data;
    } mem_req_t;

endpackage

// File: rtl/psx_rr_arbiter.sv
// Two-way round-robin grant. The pointer remembers the last granted port and
// resets to "port 1 last" so port 0 wins the first tie.
module psx_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant
);

    logic last;

    always_comb begin
        grant = (req == 2'b11) ? ~last : req[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (update) begin
            last <= grant;
        end
    end

endmodule

// File: rtl/psx_mem_arbiter.sv
// Two-port arbiter in front of a single-command memory client.
// Define PSX_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module psx_mem_arbiter
    import psx_mem_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_nRst,
    input  logic [1:0]        i_req,
    input  logic [1:0]        i_reqWrite,
    input  logic [1:0][1:0]   i_reqSize,
    input  logic [1:0][14:0]  i_reqAddr,
    input  logic [1:0][2:0]   i_reqSub,
    input  logic [1:0][15:0]  i_reqMask,
    input  logic [1:0][255:0] i_reqData,
    output logic [1:0]        o_ack,
    output logic [1:0]        o_rdValid,
    output logic [255:0]      o_rdData,
    output logic              o_command,
    output logic              o_writeElseRead,
    output logic [1:0]        o_commandSize,
    output logic [14:0]       o_targetAddr,
    output logic [2:0]        o_subAddr,
    output logic [15:0]       o_writeMask,
    output logic [255:0]      o_dataClient,
    input  logic              i_busyClient,
    input  logic              i_dataValidClient,
    input  logic [255:0]      i_dataClient
);

    arb_state_t state, state_next;
    mem_req_t   req_sel, req_q;
    logic       gnt, gnt_q;
    logic       take, cmd_next, rd_done;

`ifdef PSX_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt = i_req[1] & ~i_req[0];
    end
`else
    psx_rr_arbiter u_rr (
        .clk    (i_clk),
        .rst_n  (i_nRst),
        .req    (i_req),
        .update (take),
        .grant  (gnt)
    );
`endif

    always_comb begin
        req_sel.write = i_reqWrite[gnt];
        req_sel.size  = i_reqSize[gnt];
        req_sel.addr  = i_reqAddr[gnt];
        req_sel.sub   = i_reqSub[gnt];
        req_sel.mask  = i_reqWrite[gnt] ? i_reqMask[gnt] : '1;
        req_sel.data  = i_reqData[gnt];
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        cmd_next   = 1'b0;
        rd_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|i_req && !i_busyClient) begin
                    take       = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            // Hold the command back if the client reports busy, so a command
            // never follows a busy cycle.
            ST_ISSUE: begin
                if (!i_busyClient) begin
                    cmd_next   = 1'b1;
                    state_next = ST_GUARD;
                end
            end
            ST_GUARD: begin
                state_next = req_q.write ? ST_WAIT_WR : ST_WAIT_RD;
            end
            ST_WAIT_WR: begin
                if (!i_busyClient) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_RD: begin
                if (i_dataValidClient) begin
                    rd_done    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            o_ack     <= '0;
            o_rdValid <= '0;
            o_rdData  <= '0;
            o_command <= 1'b0;
            gnt_q     <= 1'b0;
            req_q     <= '0;
        end else begin
            o_ack     <= take ? (gnt ? 2'b10 : 2'b01) : 2'b00;
            o_rdValid <= rd_done ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
            o_command <= cmd_next;
            if (take) begin
                gnt_q <= gnt;
                req_q <= req_sel;
            end
            if (rd_done) begin
                o_rdData <= i_dataClient;
            end
        end
    end

    assign o_writeElseRead = req_q.write;
    assign o_commandSize   = req_q.size;
    assign o_targetAddr    = req_q.addr;
    assign o_subAddr       = req_q.sub;
    assign o_writeMask     = req_q.mask;
    assign o_dataClient    = req_q.data;

endmodule
